// File: rtl/sr_bank_sequencer.sv
// sr_bank_sequencer
// Shares one bank of gate-level SR flip-flops between NUM_REQ requesters.
// Arbitrates round-robin, drives clean s/r pulses (never both high on a bit)
// and keeps a shadow copy of the bank for toggle resolution and readout.
// Optional feature macro: SR_READBACK_EN adds q_fb/err readback checking.
module sr_bank_sequencer #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_BITS     = 8,
    parameter int IDX_W        = 3,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       op,
    input  logic [IDX_W*NUM_REQ-1:0]   idx,
`ifdef SR_READBACK_EN
    input  logic [NUM_BITS-1:0]        q_fb,
    output logic                       err,
`endif
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_BITS-1:0]        s_out,
    output logic [NUM_BITS-1:0]        r_out,
    output logic [NUM_BITS-1:0]        q_shadow,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_BITS-1:0]  s_q;
    logic [NUM_BITS-1:0]  r_q;
    logic [NUM_BITS-1:0]  shadow_q;
    logic                 busy_q;
    logic [PTR_W-1:0]     who_q;      // requester currently being served
    logic [NUM_BITS-1:0]  mask_q;     // one-hot target bit, 0 if index out of range
    logic                 set_q;      // resolved direction: 1 set, 0 reset
    logic                 nop_q;      // current grant needs no drive

    // Arbitration results for the current cycle
    logic                 found_d;
    logic [PTR_W-1:0]     win_d;
    logic [1:0]           win_op_d;
    logic [IDX_W-1:0]     win_idx_d;
    logic [NUM_BITS-1:0]  bit_mask_d;
    logic                 win_set_d;
    logic                 arb_en_d;
    logic [PTR_W-1:0]     ptr_next_d;

    // Round-robin search from the pointer upward with wrap, plus decode of the winner's request
    always_comb begin
        logic [2*NUM_REQ-1:0]     op_sh;
        logic [IDX_W*NUM_REQ-1:0] idx_sh;
        logic [NUM_BITS-1:0]      sh_sh;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found_d    = 1'b0;
        win_d      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int                 j;
            logic [NUM_REQ-1:0] m;
            j = (int'(ptr_q) + i) % NUM_REQ;
            m = NUM_REQ'(1) << j;
            if (!found_d && ((req & m) != '0)) begin
                found_d = 1'b1;
                win_d   = PTR_W'(j);
            end
        end
        op_sh      = op >> (2 * int'(win_d));
        idx_sh     = idx >> (IDX_W * int'(win_d));
        win_op_d   = op_sh[1:0];
        win_idx_d  = idx_sh[IDX_W-1:0];
        // Shifting past the top leaves zero, so out-of-range indices decode as no target
        bit_mask_d = NUM_BITS'(1) << win_idx_d;
        sh_sh      = shadow_q >> win_idx_d;
        // Toggle resolves against the shadow: 0 becomes set, 1 becomes reset
        win_set_d  = (win_op_d == 2'b01) || ((win_op_d == 2'b11) && !sh_sh[0]);
        arb_en_d   = found_d && ((state_q == ST_IDLE) || (state_q == ST_GAP));
        ptr_next_d = (int'(win_d) == NUM_REQ - 1) ? '0 : win_d + PTR_W'(1);
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
            who_q    <= '0;
            mask_q   <= '0;
            set_q    <= 1'b0;
            nop_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; later assignments in this block override the defaults.
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b1;
            case (state_q)
                ST_INIT: begin
                    // Pulse every r line so the physical bank matches the zeroed shadow
                    if (cnt_q == CNT_W'(PULSE_CYCLES)) begin
                        r_q     <= '0;
                        cnt_q   <= '0;
                        nop_q   <= 1'b0;
                        state_q <= ST_GAP;
                    end else begin
                        r_q   <= '1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!found_d) busy_q <= 1'b0;
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_W'(PULSE_CYCLES)) begin
                        s_q      <= '0;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        shadow_q <= set_q ? (shadow_q | mask_q) : (shadow_q & ~mask_q);
                        done_q   <= NUM_REQ'(1) << who_q;
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // A nop completes one cycle after its grant
                    if (nop_q) done_q <= NUM_REQ'(1) << who_q;
                    nop_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase

            // Grant from IDLE or directly at the end of GAP to sustain one op per P+1 cycles
            if (arb_en_d) begin
                gnt_q  <= NUM_REQ'(1) << win_d;
                ptr_q  <= ptr_next_d;
                who_q  <= win_d;
                mask_q <= bit_mask_d;
                set_q  <= win_set_d;
                cnt_q  <= CNT_W'(1);
                busy_q <= 1'b1;
                if ((win_op_d != 2'b00) && (bit_mask_d != '0)) begin
                    state_q <= ST_DRIVE;
                    nop_q   <= 1'b0;
                    if (win_set_d) s_q <= bit_mask_d;
                    else           r_q <= bit_mask_d;
                end else begin
                    state_q <= ST_GAP;
                    nop_q   <= 1'b1;
                end
            end
        end
    end

`ifdef SR_READBACK_EN
    logic from_init_q;
    logic err_q;

    // Remember whether the current GAP follows the INIT clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            from_init_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            from_init_q <= 1'b1;
        end else if (state_q == ST_GAP) begin
            from_init_q <= 1'b0;
        end
    end

    // Sticky readback mismatch flag, compared while the bank lines are quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_GAP) begin
            if (from_init_q && (q_fb != '0))
                err_q <= 1'b1;
            if (!from_init_q && (((q_fb ^ shadow_q) & mask_q) != '0))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign s_out    = s_q;
    assign r_out    = r_q;
    assign q_shadow = shadow_q;
    assign busy     = busy_q;

endmodule
